// File: rtl/bcd_sum_display.sv
// Two-digit multiplexed 7-segment display for the BCD adder's sum digit and carry.
// Optional build macro LEADING_ZERO_BLANK_EN blanks the tens digit when the carry is 0.
module bcd_sum_display #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [3:0] in_digit,
    input  logic       in_carry,
    output logic       in_ready,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       err
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    // Segment pattern {g,f,e,d,c,b,a}, active low; anything above 9 shows 'E'.
    function automatic logic [6:0] enc(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b0000110;
        endcase
        return s;
    endfunction

    logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
    logic             scan_q, scan_d;
    logic [3:0]       digit_q, digit_d;
    logic             carry_q, carry_d;
    logic             err_q, err_d;
    logic [6:0]       seg_q, seg_d;
    logic [1:0]       an_q, an_d;
    logic             cnt_last;
    logic             take;

    always_comb begin
        cnt_last  = (div_cnt_q == CNT_LAST);
        in_ready  = cnt_last & scan_q & ~rst;
        take      = in_valid & in_ready;

        div_cnt_d = cnt_last ? '0 : div_cnt_q + CNT_W'(1);
        scan_d    = scan_q;
        if (take) begin
            scan_d = 1'b0;
        end else if (cnt_last) begin
            scan_d = ~scan_q;
        end

        digit_d = digit_q;
        carry_d = carry_q;
        err_d   = err_q;
        if (take) begin
            digit_d = in_digit;
            carry_d = in_carry;
            err_d   = (in_digit > 4'd9);
        end

        // Output stage reflects the slot currently held in scan_q.
        if (scan_q) begin
            an_d = 2'b01;
`ifdef LEADING_ZERO_BLANK_EN
            seg_d = carry_q ? enc(4'd1) : 7'b1111111;
`else
            seg_d = enc({3'b000, carry_q});
`endif
        end else begin
            an_d  = 2'b10;
            seg_d = enc(digit_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q <= '0;
            scan_q    <= 1'b0;
            digit_q   <= 4'd0;
            carry_q   <= 1'b0;
            err_q     <= 1'b0;
            seg_q     <= 7'b1111111;
            an_q      <= 2'b11;
        end else begin
            div_cnt_q <= div_cnt_d;
            scan_q    <= scan_d;
            digit_q   <= digit_d;
            carry_q   <= carry_d;
            err_q     <= err_d;
            seg_q     <= seg_d;
            an_q      <= an_d;
        end
    end

    assign seg = seg_q;
    assign an  = an_q;
    assign err = err_q;

endmodule
